serial_subtractor: RTL

- Bit-serial WIDTH-bit subtractor, computing D = A - B - Bin one bit per clock, LSB first, with a single borrow flip-flop.
- It is the inverse arithmetic counterpart of the team's ripple full-adder datapath.
- It serves area-constrained datapaths that can trade latency for one full-subtractor cell.
- Operands are loaded in parallel and the result is returned in parallel, framed by a start/busy/done handshake.

---
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor.sv | 138 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if -- operand/result bundle for the bit-serial subtractor.
//   start        : request, honoured only when the block is not busy
//   A, B, Bin    : minuend, subtrahend, borrow-in (captured on accepted start)
//   busy         : bits are being processed
//   done         : one-cycle pulse, D/Bout valid from here on
//   D, Bout      : difference and final borrow-out, held until next done
//   ovf          : two's-complement overflow, present only with
//                  SERIAL_SUBTRACTOR_SIGNED_OVF_EN defined
// modport master: requester side; modport slave: subtractor side.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  logic             ovf;

  modport master (output start, A, B, Bin, input busy, done, D, Bout, ovf);
  modport slave  (input start, A, B, Bin, output busy, done, D, Bout, ovf);
`else
  modport master (output start, A, B, Bin, input busy, done, D, Bout);
  modport slave  (input start, A, B, Bin, output busy, done, D, Bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial WIDTH-bit subtractor, D = A - B - Bin.
// One full-subtractor cell and one borrow flop process a bit per clock,
// LSB first. Operands load in parallel on an accepted start, the result is
// presented in parallel with a one-cycle done pulse.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_subtractor_if.slave (start/A/B/Bin in, busy/done/D/Bout out)
// Optional: define SERIAL_SUBTRACTOR_SIGNED_OVF_EN to add the ovf output
// (two's-complement overflow of the whole subtraction).

// Full-subtractor cell: d = a - b - bi, bo = borrow out.
module serial_subtractor_fs (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;

  logic             load, step, last;
  logic             d0, bo;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  serial_subtractor_fs u_fs (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (brw),
    .d  (d0),
    .bo (bo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DONE accepts a new start exactly like IDLE so operations can run
  // back-to-back with no dead cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. D/Bout live in their own registers so the next operation
  // can shift without disturbing the previously returned result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else if (load) begin
      a_sr <= bus.A;
      b_sr <= bus.B;
      brw  <= bus.Bin;
      cnt  <= '0;
    end else if (step) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      r_sr <= {d0, r_sr[WIDTH-1:1]};
      brw  <= bo;
      cnt  <= cnt + CNT_W'(1);
      if (last) begin
        d_q    <= {d0, r_sr[WIDTH-1:1]};
        bout_q <= bo;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  // On the MSB step brw is the borrow into the sign bit and bo the borrow
  // out of it; they differ exactly when the signed result overflows.
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n)            ovf_q <= 1'b0;
    else if (step && last) ovf_q <= brw ^ bo;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
endmodule
